skinny_sbox8_dom1_byte_sequencer: RTL and testbench

Upstream/downstream controller for the 2-share DOM1 non-pipelined SKINNY sbox8. It serialises a masked 128-bit SKINNY state (two shares) one byte at a time into the sbox, holding the byte shares and the fresh refreshing mask stable for the sbox's full latency. It collects the sbox output shares back into a 128-bit two-share result and signals completion. It sits between the round-state register and the masked sbox in the SubCells step of the protected round datapath.

---
 rtl/skinny_sbox8_dom1_byte_sequencer_if.sv | 29 ++
 rtl/skinny_sbox8_dom1_byte_sequencer.sv | 155 +++++++++++++++
 tb/tb_skinny_sbox8_dom1_byte_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/skinny_sbox8_dom1_byte_sequencer_if.sv
// Bundle between the round-state register, the masked SKINNY sbox8 and the
// byte sequencer. The sequencer takes the slave side; the environment takes the master side.
interface skinny_sbox8_dom1_byte_sequencer_if;
  logic         start;
  logic         busy;
  logic         done;
  logic [127:0] si0;
  logic [127:0] si1;
  logic [127:0] so0;
  logic [127:0] so1;
  logic [7:0]   rnd;
  logic         rnd_valid;
  logic         rnd_ready;
  logic [7:0]   sb_si0;
  logic [7:0]   sb_si1;
  logic [7:0]   sb_r;
  logic [7:0]   sb_bo0;
  logic [7:0]   sb_bo1;

  modport master (
    output start, si0, si1, rnd, rnd_valid, sb_bo0, sb_bo1,
    input  busy, done, so0, so1, rnd_ready, sb_si0, sb_si1, sb_r
  );

  modport slave (
    input  start, si0, si1, rnd, rnd_valid, sb_bo0, sb_bo1,
    output busy, done, so0, so1, rnd_ready, sb_si0, sb_si1, sb_r
  );
endinterface

// File: rtl/skinny_sbox8_dom1_byte_sequencer.sv
// Byte sequencer for the 2-share DOM1 SKINNY sbox8.
// The two state shares are handled separately all the way through. They are never
// combined with each other. Each byte and its fresh mask stay in registers that feed
// the sbox directly. They hold still for the sbox latency, and the result is captured
// one cycle after the sbox output becomes valid.
//
// state | meaning
// IDLE  | waiting for start; so0/so1 hold the last result
// FETCH | waiting for a fresh mask byte (rnd_ready=1)
// HOLD  | sbox inputs frozen; counting up to SBOX_LAT, then capture
// DONE  | one-cycle completion pulse
module skinny_sbox8_dom1_byte_sequencer #(
  parameter int SBOX_LAT = 4,
  parameter int NBYTES   = 16
) (
  input logic clk,
  input logic rst_n,
  skinny_sbox8_dom1_byte_sequencer_if.slave bus
);

  localparam int SW = 8 * NBYTES;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int CW = $clog2(SBOX_LAT + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);
  localparam logic [CW-1:0] CAP_CNT  = CW'(SBOX_LAT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] buf0_q, buf0_d;
  logic [SW-1:0] buf1_q, buf1_d;
  logic [SW-1:0] so0_q, so0_d;
  logic [SW-1:0] so1_q, so1_d;
  logic [7:0]    sb_si0_q, sb_si0_d;
  logic [7:0]    sb_si1_q, sb_si1_d;
  logic [7:0]    sb_r_q, sb_r_d;

  logic          capture;
  logic [IW+2:0] byte_off;
  logic          busy_o, done_o, rnd_ready_o;

  assign byte_off = {idx_q, 3'b000};
  assign capture  = (state_q == ST_HOLD) && (cnt_q == CAP_CNT);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. start is only looked at in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.start) state_d = ST_FETCH;
      ST_FETCH: if (bus.rnd_valid) state_d = ST_HOLD;
      ST_HOLD:  if (capture) state_d = (idx_q == LAST_IDX) ? ST_DONE : ST_FETCH;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from the state register.
  always_comb begin
    busy_o      = (state_q != ST_IDLE);
    done_o      = (state_q == ST_DONE);
    rnd_ready_o = (state_q == ST_FETCH);
  end

  // Datapath next values. The sbox input registers load only on the FETCH->HOLD handshake.
  always_comb begin
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    buf0_d   = buf0_q;
    buf1_d   = buf1_q;
    so0_d    = so0_q;
    so1_d    = so1_q;
    sb_si0_d = sb_si0_q;
    sb_si1_d = sb_si1_q;
    sb_r_d   = sb_r_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          buf0_d = bus.si0;
          buf1_d = bus.si1;
          idx_d  = '0;
        end
      end
      ST_FETCH: begin
        if (bus.rnd_valid) begin
          sb_si0_d = buf0_q[byte_off +: 8];
          sb_si1_d = buf1_q[byte_off +: 8];
          sb_r_d   = bus.rnd;
          cnt_d    = '0;
        end
      end
      ST_HOLD: begin
        if (capture) begin
          so0_d[byte_off +: 8] = bus.sb_bo0;
          so1_d[byte_off +: 8] = bus.sb_bo1;
          cnt_d                = '0;
          if (idx_q != LAST_IDX) idx_d = idx_q + IW'(1);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; a reset mid-run discards everything, including partial results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q    <= '0;
      cnt_q    <= '0;
      buf0_q   <= '0;
      buf1_q   <= '0;
      so0_q    <= '0;
      so1_q    <= '0;
      sb_si0_q <= '0;
      sb_si1_q <= '0;
      sb_r_q   <= '0;
    end else begin
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      buf0_q   <= buf0_d;
      buf1_q   <= buf1_d;
      so0_q    <= so0_d;
      so1_q    <= so1_d;
      sb_si0_q <= sb_si0_d;
      sb_si1_q <= sb_si1_d;
      sb_r_q   <= sb_r_d;
    end
  end

  assign bus.busy      = busy_o;
  assign bus.done      = done_o;
  assign bus.rnd_ready = rnd_ready_o;
  assign bus.so0       = so0_q;
  assign bus.so1       = so1_q;
  assign bus.sb_si0    = sb_si0_q;
  assign bus.sb_si1    = sb_si1_q;
  assign bus.sb_r      = sb_r_q;

endmodule

// File: tb/tb_skinny_sbox8_dom1_byte_sequencer.sv
// Bench for the sbox8 byte sequencer. It includes a 4-deep masked-sbox stand-in
// and a cycle-level reference model that is checked on every negedge.
module tb_skinny_sbox8_dom1_byte_sequencer;
  localparam int SBOX_LAT = 4;
  localparam int NBYTES   = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  skinny_sbox8_dom1_byte_sequencer_if bus();

  skinny_sbox8_dom1_byte_sequencer #(.SBOX_LAT(SBOX_LAT), .NBYTES(NBYTES)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // SKINNY-128 8-bit sbox: four mix rounds with bit permutations, then a final swap.
  function automatic logic [7:0] s_mix(input logic [7:0] x);
    logic [7:0] t;
    t = (x >> 1) | x;
    t = t >> 2;
    t = ~t & 8'h11;
    return t ^ x;
  endfunction

  function automatic logic [7:0] s_perm(input logic [7:0] x);
    return ((x & 8'h01) << 2) | ((x & 8'h06) << 5) | ((x & 8'h20) >> 5) |
           ((x & 8'hC8) >> 2) | ((x & 8'h10) >> 1);
  endfunction

  function automatic logic [7:0] s8(input logic [7:0] xin);
    logic [7:0] x;
    x = xin;
    for (int r = 0; r < 4; r++) begin
      x = s_mix(x);
      if (r < 3) x = s_perm(x);
    end
    return (x & 8'hF9) | ((x >> 1) & 8'h02) | ((x << 1) & 8'h04);
  endfunction

  function automatic logic [127:0] exp_xor(input logic [127:0] a0, input logic [127:0] a1);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < NBYTES; i++) r[i*8 +: 8] = s8(a0[i*8 +: 8] ^ a1[i*8 +: 8]);
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, exp);
    end
  endtask

  // Masked sbox stand-in: share0 = S8(x)^r, share1 = r, valid SBOX_LAT edges after the inputs settle.
  logic [15:0] sb_pipe [SBOX_LAT];
  always @(posedge clk) begin
    sb_pipe[0] <= {s8(bus.sb_si0 ^ bus.sb_si1) ^ bus.sb_r, bus.sb_r};
    for (int k = 1; k < SBOX_LAT; k++) sb_pipe[k] <= sb_pipe[k-1];
  end
  assign bus.sb_bo0 = sb_pipe[SBOX_LAT-1][15:8];
  assign bus.sb_bo1 = sb_pipe[SBOX_LAT-1][7:0];

  // Reference model: m_wait counts the cycles left before the current byte is captured.
  bit           m_active, m_done;
  int           m_idx, m_wait;
  logic [127:0] m_b0, m_b1, m_so0, m_so1;
  logic [7:0]   m_sb0, m_sb1, m_sbr;
  int           acc_cyc = 0;
  int           done_cnt = 0;
  int           dut_lat = 0;

  task automatic m_reset();
    m_active = 0; m_done = 0; m_idx = 0; m_wait = 0;
    m_b0 = '0; m_b1 = '0; m_so0 = '0; m_so1 = '0;
    m_sb0 = '0; m_sb1 = '0; m_sbr = '0;
  endtask

  initial begin
    m_reset();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_reset();
        chk("rst_ctrl", {bus.busy, bus.done, bus.rnd_ready, bus.sb_si0, bus.sb_si1, bus.sb_r}, '0);
        chk("rst_so0", bus.so0, '0);
        chk("rst_so1", bus.so1, '0);
      end else begin
        chk("busy", bus.busy, m_active);
        chk("done", bus.done, m_done);
        chk("rnd_ready", bus.rnd_ready, m_active && !m_done && m_wait == 0);
        chk("so0", bus.so0, m_so0);
        chk("so1", bus.so1, m_so1);
        chk("sb_si0", bus.sb_si0, m_sb0);
        chk("sb_si1", bus.sb_si1, m_sb1);
        chk("sb_r", bus.sb_r, m_sbr);
        if (bus.done) begin
          done_cnt++;
          dut_lat = cyc - acc_cyc;
        end
        if (!m_active) begin
          if (bus.start) begin
            m_active = 1; m_b0 = bus.si0; m_b1 = bus.si1; m_idx = 0; m_wait = 0;
            acc_cyc = cyc;
          end
        end else if (m_done) begin
          m_active = 0; m_done = 0;
        end else if (m_wait == 0) begin
          if (bus.rnd_valid) begin
            m_sb0 = m_b0[m_idx*8 +: 8];
            m_sb1 = m_b1[m_idx*8 +: 8];
            m_sbr = bus.rnd;
            m_wait = SBOX_LAT + 1;
          end
        end else begin
          m_wait--;
          if (m_wait == 0) begin
            m_so0[m_idx*8 +: 8] = s8(m_b0[m_idx*8 +: 8] ^ m_b1[m_idx*8 +: 8]) ^ m_sbr;
            m_so1[m_idx*8 +: 8] = m_sbr;
            if (m_idx == NBYTES - 1) m_done = 1;
            else m_idx++;
          end
        end
      end
    end
  end

  // Randomness source: 0 = constant zero, 1 = LFSR always valid, 2 = random with gaps.
  int         rv_mode = 0;
  int         stall_idx = 0;
  int         stall_left = 0;
  logic [7:0] lfsr = 8'hA5;

  initial begin
    bus.rnd = 8'h00;
    bus.rnd_valid = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (m_active && !m_done && m_wait == 0 && m_idx == stall_idx && stall_left > 0) begin
        bus.rnd_valid = 1'b0;
        stall_left--;
      end else begin
        case (rv_mode)
          0: begin bus.rnd = 8'h00; bus.rnd_valid = 1'b1; end
          1: begin
            lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            bus.rnd = lfsr; bus.rnd_valid = 1'b1;
          end
          default: begin
            bus.rnd = 8'($urandom_range(0, 255));
            bus.rnd_valid = ($urandom_range(0, 9) < 7);
          end
        endcase
      end
    end
  end

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic launch(input logic [127:0] a0, input logic [127:0] a1);
    for (int k = 0; k < 400 && m_active; k++) @(posedge clk);
    @(posedge clk);
    #1;
    bus.si0 = a0; bus.si1 = a1; bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, input string name);
    int d0;
    bit got;
    d0 = done_cnt;
    got = 0;
    for (int k = 0; k < max_cyc; k++) begin
      @(negedge clk);
      #1;
      if (done_cnt != d0) begin got = 1; break; end
    end
    chk(name, got, 1);
  endtask

  initial begin
    logic [127:0] m, a0, a1, pat;
    int d_before;
    bit hit;
    bus.start = 1'b0; bus.si0 = '0; bus.si1 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", bus.busy, 0);
    chk("reset_so0", bus.so0, '0);
    rst_n = 1'b1;

    // Unmasked zero state.
    rv_mode = 0;
    launch('0, '0);
    wait_done(300, "zero_done");
    chk("zero_lat", dut_lat, 97);
    chk("zero_xor", bus.so0 ^ bus.so1, {16{8'h65}});

    // Masked all-ones state.
    rv_mode = 1;
    m = rand128();
    launch(m, m ^ {16{8'hFF}});
    wait_done(300, "ones_done");
    chk("ones_lat", dut_lat, 97);
    chk("ones_xor", bus.so0 ^ bus.so1, {16{8'hFF}});

    // Mixed bytes.
    m = rand128();
    pat = 128'h0000_0000_0000_0000_0000_0000_0000_FF00;
    launch(m, m ^ pat);
    wait_done(300, "mixed_done");
    chk("mixed_xor", bus.so0 ^ bus.so1, {{14{8'h65}}, 8'hFF, 8'h65});
    chk("mixed_model", bus.so0 ^ bus.so1, exp_xor(m, m ^ pat));

    // Ten-cycle randomness stall at byte 3.
    a0 = rand128(); a1 = rand128();
    stall_idx = 3; stall_left = 10;
    launch(a0, a1);
    wait_done(300, "stall_done");
    chk("stall_lat", dut_lat, 107);
    chk("stall_xor", bus.so0 ^ bus.so1, exp_xor(a0, a1));
    stall_left = 0;

    // Start pulsed mid-run at byte 5 is ignored.
    a0 = rand128(); a1 = rand128();
    d_before = done_cnt;
    launch(a0, a1);
    hit = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      #1;
      if (m_active && m_idx == 5) begin hit = 1; break; end
    end
    chk("ign_reach5", hit, 1);
    bus.si0 = rand128(); bus.si1 = rand128(); bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(300, "ign_done");
    chk("ign_xor", bus.so0 ^ bus.so1, exp_xor(a0, a1));
    repeat (20) @(posedge clk);
    #1;
    chk("ign_single_done", done_cnt - d_before, 1);
    chk("ign_idle", bus.busy, 0);
    a0 = rand128(); a1 = rand128();
    launch(a0, a1);
    wait_done(300, "ign2_done");
    chk("ign2_xor", bus.so0 ^ bus.so1, exp_xor(a0, a1));

    // Reset during HOLD of byte 7.
    d_before = done_cnt;
    launch(rand128(), rand128());
    hit = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      #1;
      if (m_active && m_idx == 7 && m_wait == 3) begin hit = 1; break; end
    end
    chk("rst_reach7", hit, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_sb", {bus.sb_si0, bus.sb_si1, bus.sb_r, bus.rnd_ready, bus.done}, '0);
    chk("midrst_so", bus.so0 | bus.so1, '0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("midrst_no_done", done_cnt, d_before);
    a0 = rand128(); a1 = rand128();
    launch(a0, a1);
    wait_done(300, "post_rst_done");
    chk("post_rst_lat", dut_lat, 97);
    chk("post_rst_xor", bus.so0 ^ bus.so1, exp_xor(a0, a1));

    // Random runs with gappy randomness.
    rv_mode = 2;
    for (int r = 0; r < 4; r++) begin
      a0 = rand128(); a1 = rand128();
      launch(a0, a1);
      wait_done(1000, "rand_done");
      chk("rand_xor", bus.so0 ^ bus.so1, exp_xor(a0, a1));
    end

    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
